// File: rtl/pixel_window_addr_gen.sv
// Paced read-address generator for a rectangular window inside a FRAME_W x FRAME_H
// frame buffer, issuing addresses on a valid/ready handshake.
module pixel_window_addr_gen #(
  parameter int FRAME_W = 320,
  parameter int FRAME_H = 240,
  parameter int ADDR_W  = 17,
  parameter int DELAY_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [ADDR_W-1:0]  win_x0,
  input  logic [ADDR_W-1:0]  win_w,
  input  logic [ADDR_W-1:0]  win_y0,
  input  logic [ADDR_W-1:0]  win_h,
  input  logic [DELAY_W-1:0] delay_cycles,
  input  logic               pixel_send_ready,
  output logic [ADDR_W-1:0]  address,
  output logic               addr_valid,
  output logic               line_last,
  output logic               frame_done,
  output logic               busy,
  output logic               cfg_err
);

  localparam logic [ADDR_W-1:0] FW   = ADDR_W'(FRAME_W);
  localparam logic [ADDR_W:0]   FW_X = (ADDR_W+1)'(FRAME_W);
  localparam logic [ADDR_W:0]   FH_X = (ADDR_W+1)'(FRAME_H);
  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, VALID, GAP, DONE} state_t;

  state_t             state;
  logic [ADDR_W-1:0]  x0_l, w_l, y0_l, h_l;
  logic [DELAY_W-1:0] delay_l;
  logic               cont_l;
  logic [ADDR_W-1:0]  line_base, col, row;
  logic [DELAY_W-1:0] gap_cnt;

  logic              cfg_bad, col_end, row_end;
  logic [ADDR_W-1:0] row_base;

  // Extra bit on the bound sums keeps an overflowing x0+w from wrapping into range.
  assign cfg_bad = (win_w == '0) || (win_h == '0) ||
                   (({1'b0, win_x0} + {1'b0, win_w}) > FW_X) ||
                   (({1'b0, win_y0} + {1'b0, win_h}) > FH_X);

  assign col_end  = (col == w_l - ONE);
  assign row_end  = (row == h_l - ONE);
  assign row_base = y0_l * FW;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      address    <= '0;
      addr_valid <= 1'b0;
      line_last  <= 1'b0;
      frame_done <= 1'b0;
      busy       <= 1'b0;
      cfg_err    <= 1'b0;
      x0_l       <= '0;
      w_l        <= '0;
      y0_l       <= '0;
      h_l        <= '0;
      delay_l    <= '0;
      cont_l     <= 1'b0;
      line_base  <= '0;
      col        <= '0;
      row        <= '0;
      gap_cnt    <= '0;
    end else begin
      frame_done <= 1'b0;
      cfg_err    <= 1'b0;
      if (abort) begin
        state      <= IDLE;
        addr_valid <= 1'b0;
        line_last  <= 1'b0;
        busy       <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              if (cfg_bad) begin
                cfg_err <= 1'b1;
              end else begin
                x0_l    <= win_x0;
                w_l     <= win_w;
                y0_l    <= win_y0;
                h_l     <= win_h;
                delay_l <= delay_cycles;
                cont_l  <= continuous;
                busy    <= 1'b1;
                state   <= LOAD;
              end
            end
          end
          LOAD: begin
            line_base  <= row_base;
            col        <= '0;
            row        <= '0;
            address    <= row_base + x0_l;
            addr_valid <= 1'b1;
            line_last  <= (w_l == ONE);
            state      <= VALID;
          end
          VALID: begin
            if (pixel_send_ready) begin
              if (col_end && row_end) begin
                addr_valid <= 1'b0;
                line_last  <= 1'b0;
                frame_done <= 1'b1;
                state      <= DONE;
              end else begin
                if (col_end) begin
                  col       <= '0;
                  row       <= row + ONE;
                  line_base <= line_base + FW;
                  address   <= line_base + FW + x0_l;
                  line_last <= (w_l == ONE);
                end else begin
                  col       <= col + ONE;
                  address   <= address + ONE;
                  line_last <= (col + ONE == w_l - ONE);
                end
                // The next address is already staged; GAP only withholds valid.
                if (delay_l != '0) begin
                  addr_valid <= 1'b0;
                  line_last  <= 1'b0;
                  gap_cnt    <= delay_l;
                  state      <= GAP;
                end
              end
            end
          end
          GAP: begin
            if (gap_cnt <= 1) begin
              addr_valid <= 1'b1;
              line_last  <= col_end;
              state      <= VALID;
            end else begin
              gap_cnt <= gap_cnt - 1'b1;
            end
          end
          DONE: begin
            busy  <= cont_l;
            state <= cont_l ? LOAD : IDLE;
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
